shift_iter_unit: RTL and testbench

- Multi-cycle shift/rotate unit built around one shared combinational shift stage. It replaces a 4-stage combinational barrel chain with a single stage applied once per clock.
- Processes the count bits MSB first (8, 4, 2, 1), one bit per cycle, into a result register.
- Sits between execute-stage operand selection and the ALU result mux. It is used where area matters more than latency.

---
 rtl/shift_iter_unit_pkg.sv | 20 ++
 rtl/shift_iter_unit_stage.sv | 34 +++
 rtl/shift_iter_unit.sv | 78 +++++++
 tb/tb_shift_iter_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/shift_iter_unit_pkg.sv
// Shared op/state encodings for the iterative shift/rotate unit.
// Stage index width follows from the four binary-weighted stage amounts (8, 4, 2, 1).
package shift_iter_unit_pkg;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int STAGE_W = 2;

endpackage

// File: rtl/shift_iter_unit_stage.sv
// Single combinational shift/rotate stage by 2^Amt (Amt=3 -> 8 ... Amt=0 -> 1).
// Zero latency; no flow control.
module shift_stage
  import shift_iter_unit_pkg::*;
(
  input  logic [15:0]        In,
  input  logic [STAGE_W-1:0] Amt,
  input  op_e                Op,
  output logic [15:0]        Out
);

  logic [4:0]  w_s;
  logic [4:0]  w_r;
  logic [15:0] w_lsh;
  logic [15:0] w_rsh;

  // w_r is the complementary amount that brings the wrapped bits around for rotates
  assign w_s   = 5'd1 << Amt;
  assign w_r   = 5'd16 - w_s;
  assign w_lsh = In << w_s;
  assign w_rsh = In >> w_s;

  always_comb begin
    Out = In;
    case (Op)
      OP_ROL:  Out = w_lsh | (In >> w_r);
      OP_SLL:  Out = w_lsh;
      OP_ROR:  Out = w_rsh | (In << w_r);
      OP_SRL:  Out = w_rsh;
      default: Out = In;
    endcase
  end

endmodule

// File: rtl/shift_iter_unit.sv
// Iterative shift/rotate: one shared stage applied per clock, count bits MSB first.
// Fixed 5-cycle start-to-done latency; start is ignored while busy, nothing is queued.
module shift_iter_unit
  import shift_iter_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic [1:0]       Op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out
);

  state_e             r_state;
  state_e             w_next;
  logic [STAGE_W-1:0] r_k;
  logic [CNT_W-1:0]   r_cnt;
  op_e                r_op;
  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   w_stage;
  logic               w_accept;

  // DONE accepts a new request so back-to-back operations lose no cycle
  assign w_accept = start && (r_state != ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_RUN;
      ST_RUN:  if (r_k == '0) w_next = ST_DONE;
      ST_DONE: w_next = w_accept ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_RUN);
    done = (r_state == ST_DONE);
  end

  shift_stage u_stage (
    .In  (r_out),
    .Amt (r_k),
    .Op  (r_op),
    .Out (w_stage)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_k   <= '1;
      r_cnt <= '0;
      r_op  <= OP_ROL;
    end else if (w_accept) begin
      r_out <= In;
      r_cnt <= Cnt;
      r_op  <= op_e'(Op);
      r_k   <= '1;
    end else if (r_state == ST_RUN) begin
      if (r_cnt[r_k]) r_out <= w_stage;
      r_k <= r_k - 1'b1;
    end
  end

  assign Out = r_out;

endmodule

// File: tb/tb_shift_iter_unit.sv
// Directed bench for shift_iter_unit: issued requests push expected result and done cycle;
// a negedge monitor pops and compares on every done pulse.
module tb_shift_iter_unit;
  import shift_iter_unit_pkg::*;

  typedef struct {
    logic [15:0] out;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] in_v = '0;
  logic [3:0]  cnt_v = '0;
  logic [1:0]  op_v = '0;
  logic        busy;
  logic        done;
  logic [15:0] out_v;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  shift_iter_unit #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .In    (in_v),
    .Cnt   (cnt_v),
    .Op    (op_v),
    .busy  (busy),
    .done  (done),
    .Out   (out_v)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; the following posedge accepts. Returns at the next negedge.
  task automatic issue(input logic [1:0] op, input logic [15:0] in,
                       input logic [3:0] cnt, input logic [15:0] exp);
    exp_t e;
    start = 1'b1;
    in_v  = in;
    cnt_v = cnt;
    op_v  = op;
    e.out = exp;
    e.cyc = cyc + 5;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    in_v  = 16'h5A5A;
    cnt_v = 4'hF;
    op_v  = OP_SRL;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("result", 32'(out_v), 32'(e.out));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("busy_with_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  // Stimulus
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out",  32'(out_v), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // ROL 8001 by 4 with latency/hold checks
    issue(OP_ROL, 16'h8001, 4'd4, 16'h0018);
    for (int i = 0; i < 4; i++) begin
      chk("busy_run", 32'(busy), 32'd1);
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    chk("done_drop", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("out_hold",  32'(out_v), 32'h0018);
    repeat (2) @(negedge clk);
    chk("out_hold2", 32'(out_v), 32'h0018);

    issue(OP_SLL, 16'h1234, 4'd4,  16'h2340); repeat (5) @(negedge clk);
    issue(OP_SRL, 16'h8000, 4'd15, 16'h0001); repeat (5) @(negedge clk);
    issue(OP_ROR, 16'h0001, 4'd1,  16'h8000); repeat (5) @(negedge clk);
    issue(OP_SRL, 16'hBEEF, 4'd0,  16'hBEEF); repeat (5) @(negedge clk);

    // start while busy is ignored
    issue(OP_SLL, 16'h00F0, 4'd4, 16'h0F00);
    @(negedge clk);
    start = 1'b1; in_v = 16'hFFFF; cnt_v = 4'd1; op_v = OP_ROL;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // back-to-back: second start in the done cycle
    issue(OP_ROL, 16'h1234, 4'd8, 16'h3412);
    repeat (4) @(negedge clk);
    issue(OP_SRL, 16'hF000, 4'd12, 16'h000F);
    repeat (5) @(negedge clk);

    // reset mid-run aborts without a done pulse
    issue(OP_ROL, 16'hAAAA, 4'd1, 16'h5555);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_out",  32'(out_v), 32'h0);
    void'(sb_q.pop_back());
    repeat (8) @(negedge clk);
    issue(OP_SLL, 16'h0001, 4'd15, 16'h8000);

    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog timeout");
  end

endmodule
